// File: rtl/ring_sequence_checker.sv
// Watches a one-hot ring counter, locks after LOCK_STEPS clean rotations,
// counts completed revolutions while locked and latches a fault on any bad sample.

package ring_sequence_checker_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;
endpackage

module ring_sequence_checker
  import ring_sequence_checker_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         phase_in,
  output logic                     locked,
  output logic                     fault,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic [CNT_W-1:0]         rev_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int SC_W  = $clog2(LOCK_STEPS + 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [SC_W-1:0]  LOCK_VAL = SC_W'(LOCK_STEPS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, next_state;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [SC_W-1:0]   step_cnt_q, step_cnt_d, step_inc;
  logic [CNT_W-1:0]  rev_q, rev_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d, sample_idx;
  logic              locked_q, fault_q;

  logic              is_valid, is_step, is_hold, is_wrap;
  logic [WIDTH-1:0]  prev_rot;

  // Sample classification against the last accepted ring value.
  assign prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign is_valid = (phase_in != '0) && ((phase_in & (phase_in - ONE)) == '0);
  assign is_step  = is_valid && (phase_in == prev_rot);
  assign is_hold  = (phase_in == prev_q);
  assign is_wrap  = prev_q[WIDTH-1];
  assign step_inc = step_cnt_q + SC_W'(1);

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (phase_in[i]) sample_idx = i[IDX_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    next_state = state;
    prev_d     = prev_q;
    step_cnt_d = step_cnt_q;
    rev_d      = rev_q;
    err_d      = err_q;
    idx_d      = idx_q;

    if (clr) begin
      next_state = IDLE;
      step_cnt_d = '0;
      rev_d      = '0;
      err_d      = '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (is_valid) begin
            prev_d     = phase_in;
            idx_d      = sample_idx;
            step_cnt_d = '0;
            next_state = ACQ;
          end
        end
        ACQ: begin
          if (is_step) begin
            prev_d     = phase_in;
            idx_d      = sample_idx;
            step_cnt_d = step_inc;
            if (step_inc == LOCK_VAL) next_state = LOCKED;
          end else if (!is_hold) begin
            next_state = IDLE;
          end
        end
        LOCKED: begin
          if (is_step) begin
            prev_d = phase_in;
            idx_d  = sample_idx;
            if (is_wrap) rev_d = rev_q + CNT_W'(1);
          end else if (!is_hold) begin
            next_state = FAULT;
            if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
          end
        end
        FAULT: ;
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every register here is small control state, so all of it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      step_cnt_q <= '0;
      rev_q      <= '0;
      err_q      <= '0;
      idx_q      <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      step_cnt_q <= step_cnt_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      locked_q   <= (next_state == LOCKED);
      fault_q    <= (next_state == FAULT);
    end
  end

  assign locked    = locked_q;
  assign fault     = fault_q;
  assign phase_idx = idx_q;
  assign rev_count = rev_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed bench for ring_sequence_checker: default instance for the main flows,
// a CNT_W=2 instance for err_count saturation.

module tb_ring_sequence_checker;
  import ring_sequence_checker_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr;
  logic [3:0] phase_in;
  logic       locked, fault;
  logic [1:0] phase_idx;
  logic [7:0] rev_count, err_count;

  logic       rst2, en2, clr2;
  logic [3:0] phase2;
  logic       locked2, fault2;
  logic [1:0] phase_idx2;
  logic [1:0] rev_count2, err_count2;

  int vectors     = 0;
  int miscompares = 0;

  ring_sequence_checker dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .phase_in(phase_in),
    .locked(locked), .fault(fault), .phase_idx(phase_idx),
    .rev_count(rev_count), .err_count(err_count)
  );

  ring_sequence_checker #(.WIDTH(4), .LOCK_STEPS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .clr(clr2), .phase_in(phase2),
    .locked(locked2), .fault(fault2), .phase_idx(phase_idx2),
    .rev_count(rev_count2), .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p);
    phase_in = p;
    tick();
  endtask

  task automatic drive2(input logic [3:0] p);
    phase2 = p;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; phase_in = 4'b0000;
    rst2 = 1'b1; en2 = 1'b0; clr2 = 1'b0; phase2 = 4'b0000;
    #2;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fault",  32'(fault), 32'd0);
    check("rst_idx",    32'(phase_idx), 32'd0);
    check("rst_rev",    32'(rev_count), 32'd0);
    check("rst_err",    32'(err_count), 32'd0);
    tick(); tick();
    rst = 1'b0; en = 1'b1;

    // Clean rotation: ACQ on 0001, lock on edge 5, first revolution on edge 9.
    drive(4'b0001); check("rot_e1_idx", 32'(phase_idx), 32'd0); check("rot_e1_lock", 32'(locked), 32'd0);
    drive(4'b0010); check("rot_e2_idx", 32'(phase_idx), 32'd1);
    drive(4'b0100); check("rot_e3_idx", 32'(phase_idx), 32'd2);
    drive(4'b1000); check("rot_e4_idx", 32'(phase_idx), 32'd3); check("rot_e4_lock", 32'(locked), 32'd0);
    drive(4'b0001); check("rot_e5_lock", 32'(locked), 32'd1); check("rot_e5_rev", 32'(rev_count), 32'd0);
    check("rot_e5_idx", 32'(phase_idx), 32'd0);
    drive(4'b0010); drive(4'b0100); drive(4'b1000);
    check("rot_e8_rev", 32'(rev_count), 32'd0);
    drive(4'b0001); check("rot_e9_rev", 32'(rev_count), 32'd1); check("rot_e9_lock", 32'(locked), 32'd1);

    // Stall tolerance: 0100 held for five samples.
    drive(4'b0010);
    drive(4'b0100);
    for (int i = 0; i < 5; i++) drive(4'b0100);
    check("stall_lock",  32'(locked), 32'd1);
    check("stall_fault", 32'(fault), 32'd0);
    check("stall_rev",   32'(rev_count), 32'd1);
    drive(4'b1000); check("stall_step_idx", 32'(phase_idx), 32'd3); check("stall_step_lock", 32'(locked), 32'd1);
    drive(4'b0001); check("stall_rev2", 32'(rev_count), 32'd2);

    // Enable low: garbage input is ignored.
    en = 1'b0;
    drive(4'b1111); drive(4'b1111);
    check("en0_lock",  32'(locked), 32'd1);
    check("en0_fault", 32'(fault), 32'd0);
    check("en0_idx",   32'(phase_idx), 32'd0);
    check("en0_rev",   32'(rev_count), 32'd2);
    en = 1'b1;
    drive(4'b0010); check("en1_idx", 32'(phase_idx), 32'd1); check("en1_lock", 32'(locked), 32'd1);

    // Fault while locked, then clear.
    drive(4'b0110);
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_lock",  32'(locked), 32'd0);
    check("flt_err",   32'(err_count), 32'd1);
    drive(4'b0100); drive(4'b1000);
    check("flt_hold_fault", 32'(fault), 32'd1);
    check("flt_hold_err",   32'(err_count), 32'd1);
    check("flt_hold_idx",   32'(phase_idx), 32'd1);
    clr = 1'b1; drive(4'b1000); clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_lock",  32'(locked), 32'd0);
    check("clr_err",   32'(err_count), 32'd0);
    check("clr_rev",   32'(rev_count), 32'd0);
    check("clr_idx",   32'(phase_idx), 32'd1);

    // Bad sample during acquisition returns to IDLE silently, then re-lock.
    drive(4'b0001); drive(4'b0010); drive(4'b0000);
    check("acqbad_fault", 32'(fault), 32'd0);
    check("acqbad_err",   32'(err_count), 32'd0);
    check("acqbad_lock",  32'(locked), 32'd0);
    drive(4'b0100); drive(4'b1000); drive(4'b0001); drive(4'b0010);
    check("acqbad_pre_lock", 32'(locked), 32'd0);
    drive(4'b0100);
    check("acqbad_relock", 32'(locked), 32'd1);
    check("acqbad_idx",    32'(phase_idx), 32'd2);
    drive(4'b1000); drive(4'b0001);
    check("pre_rst_rev", 32'(rev_count), 32'd1);

    // Asynchronous reset between edges while locked.
    #3;
    rst = 1'b1;
    #1;
    check("arst_lock", 32'(locked), 32'd0);
    check("arst_rev",  32'(rev_count), 32'd0);
    check("arst_idx",  32'(phase_idx), 32'd0);
    check("arst_err",  32'(err_count), 32'd0);
    tick();
    rst = 1'b0;
    drive(4'b0100);
    check("post_rst_idx",  32'(phase_idx), 32'd2);
    check("post_rst_lock", 32'(locked), 32'd0);

    // err_count saturation on the CNT_W=2 instance; clr never used.
    tick();
    rst2 = 1'b0; en2 = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      drive2(4'b0001); drive2(4'b0010); drive2(4'b0100); drive2(4'b1000); drive2(4'b0001);
      check($sformatf("sat_lock_%0d", f), 32'(locked2), 32'd1);
      drive2(4'b0110);
      check($sformatf("sat_fault_%0d", f), 32'(fault2), 32'd1);
      check($sformatf("sat_err_%0d", f), 32'(err_count2), (f < 3) ? 32'(f) : 32'd3);
      en2 = 1'b0;
      force dut2.state = IDLE;
      tick();
      release dut2.state;
      check($sformatf("sat_exit_%0d", f), 32'(fault2), 32'd0);
      en2 = 1'b1;
    end
    check("sat_final_err", 32'(err_count2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
